// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard: tracks in-flight write-backs per register,
// raises a combinational stall on RAW hazards, and counts stall cycles.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 16,
  parameter int WB_LATENCY = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [3:0]          src1,
  input  logic [3:0]          src2,
  input  logic                two_src,
  input  logic                id_wb_en,
  input  logic [3:0]          id_dest,
  input  logic                flush,
  input  logic                freeze,
  output logic                hazard,
  output logic                issue,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    hazard_cycles
);

  localparam logic [2:0] LOAD_VAL = 3'(WB_LATENCY);

  logic [2:0]          cnt_q [NUM_REGS];
  logic [2:0]          cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]    hazard_cycles_q;
  logic [CNT_W-1:0]    hazard_cycles_d;

  // Pending bits are a pure decode of the countdown flops, so they change only on clock or reset.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = (cnt_q[r] != 3'd0);
    end
  end

  assign hazard = id_valid & ~flush & (pending[src1] | (two_src & pending[src2]));
  assign issue  = id_valid & ~hazard & ~flush & ~freeze;

  // NOTE: start from the held value so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (cnt_q[r] != 3'd0) cnt_d[r] = cnt_q[r] - 3'd1;
      end
      // A fresh issue reloads its destination, overriding that entry's decrement.
      if (issue && id_wb_en) cnt_d[id_dest] = LOAD_VAL;
    end
  end

  always_comb begin
    hazard_cycles_d = hazard_cycles_q;
    if (hazard && !freeze && (hazard_cycles_q != '1)) begin
      hazard_cycles_d = hazard_cycles_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the countdown array is
  // flops rather than a RAM, so it is safe and required to clear it on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= 3'd0;
      hazard_cycles_q <= '0;
    end else begin
      cnt_q           <= cnt_d;
      hazard_cycles_q <= hazard_cycles_d;
    end
  end

  assign pending_mask  = pending;
  assign hazard_cycles = hazard_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: linear stimulus with hand-computed
// expectations; a second instance with a 2-bit counter exercises saturation.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, two_src, id_wb_en, flush, freeze;
  logic [3:0]  src1, src2, id_dest;
  logic        hazard, issue, hazard_s, issue_s;
  logic [15:0] pending_mask, pending_mask_s;
  logic [15:0] hazard_cycles;
  logic [1:0]  hazard_cycles_s;

  int vectors     = 0;
  int miscompares = 0;
  int exp_hc      = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest), .flush(flush),
    .freeze(freeze), .hazard(hazard), .issue(issue), .pending_mask(pending_mask),
    .hazard_cycles(hazard_cycles)
  );

  hazard_scoreboard #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .two_src(two_src), .id_wb_en(id_wb_en), .id_dest(id_dest), .flush(flush),
    .freeze(freeze), .hazard(hazard_s), .issue(issue_s), .pending_mask(pending_mask_s),
    .hazard_cycles(hazard_cycles_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_id(input string tag, input logic hz, input logic is, input logic [15:0] pm);
    check({tag, "_hazard"}, 32'(hazard), 32'(hz));
    check({tag, "_issue"},  32'(issue),  32'(is));
    check({tag, "_mask"},   32'(pending_mask), 32'(pm));
  endtask

  task automatic check_hc(input string tag);
    check({tag, "_hc"}, 32'(hazard_cycles), 32'(exp_hc));
    check({tag, "_hc_sat"}, 32'(hazard_cycles_s), (exp_hc > 3) ? 32'd3 : 32'(exp_hc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; id_valid = 1'b0; two_src = 1'b0; id_wb_en = 1'b0;
    flush = 1'b0; freeze = 1'b0; src1 = 4'd0; src2 = 4'd0; id_dest = 4'd0;
    #2;
    expect_id("reset", 1'b0, 1'b0, 16'h0000);
    check_hc("reset");
    rst = 1'b1;
    tick();

    // No prior writes: a plain read issues immediately.
    id_valid = 1'b1; src1 = 4'd2;
    #1 expect_id("t1_nodep", 1'b0, 1'b1, 16'h0000);

    // Self-dependence on r15 with nothing pending: no hazard, r15 gets tracked.
    src1 = 4'd15; id_wb_en = 1'b1; id_dest = 4'd15;
    #1 expect_id("self15", 1'b0, 1'b1, 16'h0000);
    tick();
    id_valid = 1'b0; id_wb_en = 1'b0;
    #1 check("r15_set", 32'(pending_mask), 32'h8000);
    tick(); tick(); tick();
    check("r15_clear", 32'(pending_mask), 32'h0000);

    // Producer r5, consumer on r5 the next cycle: three stall cycles.
    id_valid = 1'b1; src1 = 4'd0; id_wb_en = 1'b1; id_dest = 4'd5;
    #1 check("t2_prod_issue", 32'(issue), 32'd1);
    tick();
    id_wb_en = 1'b0; src1 = 4'd5;
    for (int i = 0; i < 3; i++) begin
      #1 expect_id("t2_stall", 1'b1, 1'b0, 16'h0020);
      tick();
    end
    exp_hc += 3;
    expect_id("t2_go", 1'b0, 1'b1, 16'h0000);
    check_hc("t2");

    // Producer r4, consumer reads r4 on src2 with two_src=1.
    src1 = 4'd0; two_src = 1'b0; id_wb_en = 1'b1; id_dest = 4'd4;
    tick();
    id_wb_en = 1'b0; two_src = 1'b1; src1 = 4'd1; src2 = 4'd4;
    for (int i = 0; i < 3; i++) begin
      #1 expect_id("t3_stall", 1'b1, 1'b0, 16'h0010);
      tick();
    end
    exp_hc += 3;
    expect_id("t3_go", 1'b0, 1'b1, 16'h0000);
    check_hc("t3");

    // Same again but src2 is not read: no hazard although r4 is pending.
    src1 = 4'd0; two_src = 1'b0; id_wb_en = 1'b1; id_dest = 4'd4;
    tick();
    id_wb_en = 1'b0; src1 = 4'd1; src2 = 4'd4;
    #1 expect_id("t3_onesrc", 1'b0, 1'b1, 16'h0010);
    id_valid = 1'b0;
    tick(); tick(); tick();
    check("t3_drain", 32'(pending_mask), 32'h0000);

    // Producer r5, then two freeze cycles with the consumer already in ID.
    id_valid = 1'b1; src1 = 4'd0; id_wb_en = 1'b1; id_dest = 4'd5;
    tick();
    id_wb_en = 1'b0; src1 = 4'd5; freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 expect_id("t4_frz", 1'b1, 1'b0, 16'h0020);
      tick();
    end
    check_hc("t4_frz");
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 expect_id("t4_stall", 1'b1, 1'b0, 16'h0020);
      tick();
    end
    exp_hc += 3;
    expect_id("t4_go", 1'b0, 1'b1, 16'h0000);
    check_hc("t4");

    // Producer r6, then a flushed writer to r7 that also reads r6.
    src1 = 4'd0; id_wb_en = 1'b1; id_dest = 4'd6;
    tick();
    flush = 1'b1; src1 = 4'd6; id_dest = 4'd7;
    #1 expect_id("t5_flush", 1'b0, 1'b0, 16'h0040);
    tick();
    flush = 1'b0; id_valid = 1'b0; id_wb_en = 1'b0;
    #1 check("t5_mask_a", 32'(pending_mask), 32'h0040);
    tick();
    check("t5_mask_b", 32'(pending_mask), 32'h0040);
    tick();
    check("t5_mask_c", 32'(pending_mask), 32'h0000);
    check_hc("t5");

    // Back-to-back writes to r3: the stall is timed from the second write.
    id_valid = 1'b1; src1 = 4'd0; id_wb_en = 1'b1; id_dest = 4'd3;
    tick();
    tick();
    id_wb_en = 1'b0; src1 = 4'd3;
    #1 expect_id("t6_stall1", 1'b1, 1'b0, 16'h0008);
    tick();
    expect_id("t6_stall2", 1'b1, 1'b0, 16'h0008);
    tick();
    expect_id("t6_stall3", 1'b1, 1'b0, 16'h0008);
    exp_hc += 2;
    check_hc("t6");

    // Asynchronous reset in the middle of the stall.
    #1 rst = 1'b0;
    #1;
    check("t6_rst_hazard", 32'(hazard), 32'd0);
    check("t6_rst_mask", 32'(pending_mask), 32'h0000);
    exp_hc = 0;
    check_hc("t6_rst");
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Scoreboard and stall controller for the decode stage of the 5-stage ARM-subset pipeline.
- Tracks which architectural registers have a write-back still in flight.
- Raises `hazard` to ID so that ID zeroes its control outputs and IF/ID hold.
- Honours a branch flush from EXE and a global memory freeze; keeps a hazard-cycle performance counter.

Parameters:
- NUM_REGS, 16, number of architectural registers tracked (index width fixed at 4).
- WB_LATENCY, 3, cycles from a write-issuing instruction leaving ID until its result is readable by ID. Legal range 1..7.
- CNT_W, 16, width of the saturating hazard-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction this cycle.
- src1  in  4  first source register (Rn).
- src2  in  4  second source register (Rm, or Rd for stores).
- two_src  in  1  src2 is actually read.
- id_wb_en  in  1  ID instruction writes a register (pre-hazard control value).
- id_dest  in  4  destination register of the ID instruction.
- flush  in  1  taken branch resolved in EXE this cycle.
- freeze  in  1  memory stall: whole pipeline holds.
- hazard  out  1  stall request to ID/IF, combinational.
- issue  out  1  ID instruction advances this cycle, combinational.
- pending_mask  out  NUM_REGS  bit r set while reg r has an in-flight write, registered.
- hazard_cycles  out  CNT_W  saturating count of cycles with hazard=1, registered.

Behaviour:
- Per register r, keep a countdown cnt[r] of width 3. `pending_mask[r] = (cnt[r] != 0)`.
- Reset (rst=0, async): all cnt = 0, pending_mask = 0, hazard_cycles = 0. hazard and issue then evaluate to 0 for as long as id_valid=0.
- hazard = id_valid & ~flush & (pending[src1] | (two_src & pending[src2])). flush has priority and forces hazard=0.
- issue = id_valid & ~hazard & ~flush & ~freeze.
- Counter update on each rising edge when freeze=0:
  - Every nonzero cnt decrements by 1.
  - Then, if issue & id_wb_en, cnt[id_dest] <= WB_LATENCY. This load overrides the decrement of the same entry, so re-issue to a pending register restarts its countdown.
- freeze=1: all cnt hold, no load, hazard_cycles holds. hazard is still computed combinationally.
- flush=1: the ID instruction is squashed. It creates no entry and hazard=0. Existing entries keep decrementing, because older instructions still complete.
- Self-dependence (src1==id_dest) with no pending entry: no hazard; the read precedes the write.
- Writes to r15 are tracked like any other register.
- hazard_cycles increments when hazard=1 and freeze=0, and saturates at all-ones.
- Latency:
  - A dependent instruction entering ID the cycle after its producer issued sees hazard for exactly WB_LATENCY cycles when freeze stays 0.
  - Each freeze cycle during that window adds one stall cycle.
- Reset asserted mid-stall clears the scoreboard immediately; hazard drops in the same cycle.

Test Plan:
- Reset, then id_valid=1, src1=2, two_src=0, with no prior writes: hazard=0, issue=1, pending_mask=0.
- Issue a producer (id_wb_en=1, id_dest=5); next cycle a consumer with src1=5: hazard=1 for 3 cycles, issue=1 on the 4th, pending_mask=0x0020 then 0, hazard_cycles=3.
- Producer to r4, then consumer with two_src=1, src1=1, src2=4: hazard=1 for 3 cycles. Repeat with two_src=0: no hazard.
- Producer to r5, freeze=1 for 2 cycles, then consumer on r5: cnt holds during freeze; total hazard cycles seen = 3 (freeze excluded from hazard_cycles).
- Producer to r6; during the next cycle flush=1 with id_valid=1, id_wb_en=1, id_dest=7: hazard=0, issue=0, bit 7 never set, bit 6 still clears after 3 cycles.
- Two back-to-back writes to r3, then consumer on r3: stall length measured from the second write (3 cycles). Assert rst=0 mid-stall: pending_mask=0 and hazard=0 asynchronously.
